// File: rtl/apb_pack_arbiter_pkg.sv
// Shared pack-format definitions for the APB request path: field positions, legal sel codes, arbiter states.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
// Ports: none (package apb_pack_pkg, also intended for the APB master decoder).
package apb_pack_pkg;

  // Ctrl pack: [0] flag=0, [1] write, [7:2] one-hot sel, [31:8] addr.
  // Data pack: [0] flag=1, [31:1] data.
  localparam int FLAG_BIT  = 0;
  localparam int WRITE_BIT = 1;
  localparam int SEL_LSB   = 2;
  localparam int SEL_MSB   = 7;
  localparam int ADDR_LSB  = 8;
  localparam int ADDR_MSB  = 31;
  localparam int SEL_W     = SEL_MSB - SEL_LSB + 1;

  // Bit i set means sel code (1 << i) is a slave the APB master can reach.
  localparam logic [SEL_W-1:0] SEL_LEGAL_DEFAULT = 6'b001111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CTRL = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } arb_state_t;

  // A sel field is usable only if it is exactly one-hot and that bit is enabled in the mask.
  function automatic logic sel_legal(input logic [SEL_W-1:0] sel, input logic [SEL_W-1:0] mask);
    return (sel != '0) && ((sel & (sel - SEL_W'(1))) == '0) && ((sel & ~mask) == '0);
  endfunction

endpackage

// File: rtl/apb_pack_arbiter_if.sv
// Bundles requester pack handshakes and the write-FIFO push port of the pack arbiter.
// Latency: n/a (wires only).
// Backpressure: req_rdy per requester; fifo_full stalls the forwarding side.
// Ports: req_vld/req_data/req_rdy (N_REQ requesters, 32-bit words), fifo_full/fifo_wdata/fifo_wen, grant_id, busy, err_drop.
interface apb_pack_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ*32-1:0] req_data;
  logic [N_REQ-1:0]    req_rdy;
  logic                fifo_full;
  logic [31:0]         fifo_wdata;
  logic                fifo_wen;
  logic [GW-1:0]       grant_id;
  logic                busy;
  logic                err_drop;

  // Arbiter side.
  modport slave (
    input  req_vld, req_data, fifo_full,
    output req_rdy, fifo_wdata, fifo_wen, grant_id, busy, err_drop
  );

  // Producer / FIFO side.
  modport master (
    output req_vld, req_data, fifo_full,
    input  req_rdy, fifo_wdata, fifo_wen, grant_id, busy, err_drop
  );
endinterface

// File: rtl/apb_pack_arbiter_rr_arbiter.sv
// Round-robin pick: first requesting index strictly after last_i, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; found_o low when no request is pending.
// Ports: req_i (request vector), last_i (previous winner), win_o (winner index), found_o (any request).
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] win_o,
  output logic         found_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester after last_i is written last and wins.
  always_comb begin
    win_o   = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N;
      if (req_i[idx[W-1:0]]) begin
        win_o   = idx[W-1:0];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_pack_arbiter.sv
// Shares the APB-request write FIFO among N_REQ producers, forwarding whole packets atomically and dropping malformed ones.
// Latency: 1 arbitration cycle per packet, then zero-latency pass-through of each accepted word.
// Backpressure: fifo_full deasserts the granted req_rdy in CTRL/DATA; DROP ignores fifo_full.
// Ports: clk, rst_n (async active-low), bus (apb_pack_arbiter_if.slave: requester handshakes, FIFO push, grant_id, busy, err_drop).
module apb_pack_arbiter
  import apb_pack_pkg::*;
#(
  parameter int         N_REQ    = 4,
  parameter logic [5:0] SEL_MASK = SEL_LEGAL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apb_pack_arbiter_if.slave     bus
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_last_q, rr_last_d;
  logic [GW-1:0] rr_win;
  logic          rr_found;

  logic [31:0]   g_word;
  logic          g_vld;
  logic          g_rdy;
  logic          ctrl_ok;
  logic          wen;
  logic [31:0]   wdata;
  logic          err;

  assign g_word  = bus.req_data[int'(grant_q)*32 +: 32];
  assign g_vld   = bus.req_vld[grant_q];
  assign ctrl_ok = !g_word[FLAG_BIT] && sel_legal(g_word[SEL_MSB:SEL_LSB], SEL_MASK);

  rr_arbiter #(
    .N (N_REQ),
    .W (GW)
  ) u_rr (
    .req_i   (bus.req_vld),
    .last_i  (rr_last_q),
    .win_o   (rr_win),
    .found_o (rr_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_last_q <= GW'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    g_rdy     = 1'b0;
    wen       = 1'b0;
    wdata     = '0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        // Arbitration only latches the winner; no word is consumed here.
        if (rr_found) begin
          grant_d = rr_win;
          state_d = CTRL;
        end
      end
      CTRL: begin
        g_rdy = !bus.fifo_full;
        wdata = g_word;
        if (g_vld && g_rdy) begin
          if (ctrl_ok) begin
            wen = 1'b1;
            if (g_word[WRITE_BIT]) begin
              state_d = DATA;
            end else begin
              state_d   = IDLE;
              rr_last_d = grant_q;
            end
          end else begin
            err = 1'b1;
            // A bad write ctrl still has a data word behind it that must be swallowed.
            if (!g_word[FLAG_BIT] && g_word[WRITE_BIT]) begin
              state_d = DROP;
            end else begin
              state_d   = IDLE;
              rr_last_d = grant_q;
            end
          end
        end
      end
      DATA: begin
        g_rdy = !bus.fifo_full;
        wdata = g_word;
        if (g_vld && g_rdy) begin
          // A ctrl word where data was expected is discarded; the ctrl already pushed stays in the FIFO.
          wen       = g_word[FLAG_BIT];
          err       = !g_word[FLAG_BIT];
          state_d   = IDLE;
          rr_last_d = grant_q;
        end
      end
      DROP: begin
        // Nothing is written, so the FIFO level is irrelevant here.
        g_rdy = 1'b1;
        if (g_vld) begin
          state_d   = IDLE;
          rr_last_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_rdy    = g_rdy ? (N_REQ'(1) << grant_q) : '0;
  assign bus.fifo_wen   = wen;
  assign bus.fifo_wdata = wdata;
  assign bus.err_drop   = err;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_apb_pack_arbiter.sv
// Self-checking bench for apb_pack_arbiter: directed scenarios plus a randomized packet-level scoreboard.
// Latency: n/a.
// Backpressure: exercises fifo_full stalls and mid-packet producer gaps.
module tb_apb_pack_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_pack_arbiter_if #(.N_REQ(N)) bus ();

  apb_pack_arbiter #(
    .N_REQ    (N),
    .SEL_MASK (6'b001111)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Producer state: pending words and packet lengths per requester.
  logic [31:0] dq [N][$];
  int          pl [N][$];
  int          pos [N];
  // Observed FIFO traffic.
  logic [31:0] obs_q [$];
  int          obs_gnt [$];
  int          obs_cyc [$];
  int          obs_err;
  int          rdy1_early;
  int          cyc;
  bit          gap_en;
  bit          full_rand;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      pl[i].delete();
      pos[i] = 0;
    end
    obs_q.delete();
    obs_gnt.delete();
    obs_cyc.delete();
    obs_err    = 0;
    rdy1_early = 0;
    cyc        = 0;
    gap_en     = 1'b0;
    full_rand  = 1'b0;
  endtask

  task automatic do_reset();
    bus.req_vld   = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_all();
  endtask

  task automatic add_pkt(input int r, input int len, input logic [31:0] w0, input logic [31:0] w1);
    dq[r].push_back(w0);
    if (len == 2) dq[r].push_back(w1);
    pl[r].push_back(len);
  endtask

  // One clock of producer behaviour; entered and left at posedge+1.
  task automatic run_cycle();
    logic [N-1:0]    v;
    logic [N*32-1:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (dq[i].size() > 0) begin
        v[i] = !(gap_en && pos[i] > 0 && $urandom_range(0, 2) == 0);
        d[32*i +: 32] = dq[i][0];
      end
    end
    bus.req_vld   = v;
    bus.req_data  = d;
    bus.fifo_full = full_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    #4;
    if (bus.req_rdy[1] && obs_q.size() < 2) rdy1_early++;
    if (bus.fifo_wen) begin
      obs_q.push_back(bus.fifo_wdata);
      obs_gnt.push_back(int'(bus.grant_id));
      obs_cyc.push_back(cyc);
    end
    if (bus.err_drop) obs_err++;
    for (int i = 0; i < N; i++) begin
      if (v[i] && bus.req_rdy[i]) begin
        void'(dq[i].pop_front());
        pos[i]++;
        if (pl[i].size() > 0 && pos[i] == pl[i][0]) begin
          void'(pl[i].pop_front());
          pos[i] = 0;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
    bus.req_vld = '0;
  endtask

  task automatic test_reset();
    bus.req_vld   = '1;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy got %b exp 0000", bus.req_rdy); end
    checks++; if (bus.fifo_wen !== 1'b0) begin errors++; $display("FAIL reset_fifo_wen got %b exp 0", bus.fifo_wen); end
    checks++; if (bus.fifo_wdata !== 32'h0) begin errors++; $display("FAIL reset_fifo_wdata got %h exp 0", bus.fifo_wdata); end
    checks++; if (bus.err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop got %b exp 0", bus.err_drop); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", bus.grant_id); end
    do_reset();
  endtask

  task automatic test_write_packet();
    do_reset();
    add_pkt(0, 2, 32'h00001006, 32'h2468ACF1);
    run_n(5);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL wr_count got %0d exp 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0] !== 32'h00001006) begin errors++; $display("FAIL wr_ctrl got %h exp 00001006", obs_q[0]); end
      checks++; if (obs_q[1] !== 32'h2468ACF1) begin errors++; $display("FAIL wr_data got %h exp 2468acf1", obs_q[1]); end
      checks++; if (obs_cyc[0] != 1 || obs_cyc[1] != 2) begin errors++; $display("FAIL wr_timing got %0d,%0d exp 1,2", obs_cyc[0], obs_cyc[1]); end
      checks++; if (obs_gnt[0] != 0 || obs_gnt[1] != 0) begin errors++; $display("FAIL wr_grant got %0d,%0d exp 0,0", obs_gnt[0], obs_gnt[1]); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b exp 0", bus.busy); end
  endtask

  task automatic test_interleave();
    logic [31:0] exp_w [3];
    exp_w = '{32'h00001006, 32'h2468ACF1, 32'h00002008};
    do_reset();
    add_pkt(0, 2, 32'h00001006, 32'h2468ACF1);
    add_pkt(1, 1, 32'h00002008, 32'h0);
    run_n(8);
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL il_count got %0d exp 3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_w[k]) begin errors++; $display("FAIL il_word%0d got %h exp %h", k, obs_q[k], exp_w[k]); end
    end
    checks++; if (rdy1_early != 0) begin errors++; $display("FAIL il_rdy1_early got %0d exp 0", rdy1_early); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++)
        add_pkt(i, 1, {8'h0, 8'(k), 8'(i), 6'b000001, 2'b00}, 32'h0);
    run_n(20);
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL fair_count got %0d exp 8", obs_q.size()); end
    for (int k = 0; k < 8 && k < obs_gnt.size(); k++) begin
      checks++;
      if (obs_gnt[k] != k % N) begin errors++; $display("FAIL fair_grant%0d got %0d exp %0d", k, obs_gnt[k], k % N); end
      if (k > 0) begin
        checks++;
        if (obs_cyc[k] - obs_cyc[k-1] != 2) begin errors++; $display("FAIL fair_gap%0d got %0d exp 2", k, obs_cyc[k] - obs_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_malformed();
    do_reset();
    add_pkt(2, 2, 32'h0000300E, 32'h00000003);
    run_n(6);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mal_writes got %0d exp 0", obs_q.size()); end
    checks++; if (obs_err != 1) begin errors++; $display("FAIL mal_err_pulses got %0d exp 1", obs_err); end
    checks++; if (dq[2].size() != 0) begin errors++; $display("FAIL mal_consumed left %0d exp 0", dq[2].size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mal_busy_end got %b exp 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.fifo_full = 1'b1;
    bus.req_vld   = 4'b1000;
    bus.req_data  = {32'h00004004, 96'h0};
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      #4;
      checks++;
      if (bus.req_rdy[3] !== 1'b0 || bus.fifo_wen !== 1'b0 || bus.busy !== 1'b1 || bus.grant_id !== 2'd3) begin
        errors++;
        $display("FAIL bp_stall%0d rdy=%b wen=%b busy=%b gnt=%0d exp 0 0 1 3", k, bus.req_rdy[3], bus.fifo_wen, bus.busy, bus.grant_id);
      end
      @(posedge clk);
    end
    #1 bus.fifo_full = 1'b0;
    #1;
    checks++;
    if (bus.fifo_wen !== 1'b1 || bus.fifo_wdata !== 32'h00004004 || bus.req_rdy !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release wen=%b wdata=%h rdy=%b exp 1 00004004 1000", bus.fifo_wen, bus.fifo_wdata, bus.req_rdy);
    end
    @(posedge clk);
    #1 bus.req_vld = '0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end got %b exp 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_vld  = 4'b0010;
    bus.req_data = {64'h0, 32'h00003006, 32'h0};
    @(posedge clk);
    @(posedge clk);
    #1 bus.req_data = {64'h0, 32'h0000000F, 32'h0};
    #2;
    checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL rm_in_data busy=%b gnt=%0d exp 1 1", bus.busy, bus.grant_id); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.req_rdy !== 4'b0000 || bus.grant_id !== 2'd0 || bus.fifo_wen !== 1'b0) begin
      errors++;
      $display("FAIL rm_async busy=%b rdy=%b gnt=%0d wen=%b exp 0 0000 0 0", bus.busy, bus.req_rdy, bus.grant_id, bus.fifo_wen);
    end
    bus.req_vld = '0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.req_vld  = 4'b1001;
    bus.req_data = {32'h00005004, 64'h0, 32'h00006004};
    @(posedge clk);
    #1;
    checks++;
    if (bus.grant_id !== 2'd0 || bus.req_rdy !== 4'b0001) begin
      errors++;
      $display("FAIL rm_rearb gnt=%0d rdy=%b exp 0 0001", bus.grant_id, bus.req_rdy);
    end
    bus.req_vld = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] mq [N][$];
    logic [31:0] exp_q [$];
    int          exp_gnt [$];
    int          exp_err;
    int          last;
    int          g;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [5:0]  sel;
    logic [5:0]  bad_sel [6];
    logic [23:0] addr;
    bit          any;
    int          left;

    bad_sel = '{6'd0, 6'd3, 6'd16, 6'd32, 6'd12, 6'd48};
    do_reset();

    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 6; p++) begin
        int t;
        t    = $urandom_range(0, 4);
        addr = 24'($urandom);
        sel  = 6'(1 << $urandom_range(0, 3));
        case (t)
          0: add_pkt(i, 1, {addr, sel, 1'b0, 1'b0}, 32'h0);
          1: add_pkt(i, 2, {addr, sel, 1'b1, 1'b0}, {31'($urandom), 1'b1});
          2: add_pkt(i, 2, {addr, sel, 1'b1, 1'b0}, {31'($urandom), 1'b0});
          3: add_pkt(i, 2, {addr, bad_sel[$urandom_range(0, 5)], 1'b1, 1'b0}, 32'($urandom));
          default: begin
            if ($urandom_range(0, 1) == 0) add_pkt(i, 1, {addr, bad_sel[$urandom_range(0, 5)], 1'b0, 1'b0}, 32'h0);
            else                           add_pkt(i, 1, {addr, 6'($urandom), 1'($urandom), 1'b1}, 32'h0);
          end
        endcase
      end
      mq[i] = dq[i];
    end

    // Packet-level reference: round-robin over requesters that still have packets.
    exp_err = 0;
    last    = N - 1;
    any     = 1'b1;
    while (any) begin
      any = 1'b0;
      g   = -1;
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && mq[(last + k) % N].size() > 0) g = (last + k) % N;
      end
      if (g >= 0) begin
        any = 1'b1;
        w0  = mq[g].pop_front();
        sel = w0[7:2];
        if (w0[0] == 1'b0 && (sel inside {6'd1, 6'd2, 6'd4, 6'd8})) begin
          exp_q.push_back(w0);
          exp_gnt.push_back(g);
          if (w0[1]) begin
            w1 = mq[g].pop_front();
            if (w1[0]) begin
              exp_q.push_back(w1);
              exp_gnt.push_back(g);
            end else begin
              exp_err++;
            end
          end
        end else begin
          exp_err++;
          if (w0[0] == 1'b0 && w0[1]) void'(mq[g].pop_front());
        end
        last = g;
      end
    end

    gap_en    = 1'b1;
    full_rand = 1'b1;
    left      = 1;
    for (int c = 0; c < 4000 && (left > 0 || bus.busy); c++) begin
      run_cycle();
      left = 0;
      for (int i = 0; i < N; i++) left += dq[i].size();
    end
    bus.req_vld   = '0;
    bus.fifo_full = 1'b0;
    gap_en        = 1'b0;
    full_rand     = 1'b0;

    checks++; if (left != 0) begin errors++; $display("FAIL rnd_timeout words_left %0d exp 0", left); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k] || obs_gnt[k] != exp_gnt[k]) begin
        errors++;
        $display("FAIL rnd_word%0d got %h/g%0d exp %h/g%0d", k, obs_q[k], obs_gnt[k], exp_q[k], exp_gnt[k]);
      end
    end
    checks++; if (obs_err != exp_err) begin errors++; $display("FAIL rnd_err_pulses got %0d exp %0d", obs_err, exp_err); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_vld   = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    clear_all();
    test_reset();
    test_write_packet();
    test_interleave();
    test_fairness();
    test_malformed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
